logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, registered bitwise logic unit. Successor to the single-op combinational AND with zero flag.
- Operations: eight bitwise ops on N-bit operands, selected per transaction.
- Outputs: result with Z (zero), N (MSB), P (odd parity) flags.
- Accumulate mode: the previous result feeds back as operand A.
- Sits between the operand/control path and the ALU result mux. Uses a valid/ready handshake so downstream stalls back-pressure cleanly.

Parameters:
N, 4, operand/result width in bits (>=2)
CNT_W, 8, width of the accepted-transaction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operands/op valid
in_ready  out  1  block can accept this cycle
a  in  N  operand A (ignored when acc_mode=1)
b  in  N  operand B
op  in  3  operation select (see Behaviour)
acc_mode  in  1  1 = use accumulator as operand A
acc_clr  in  1  synchronous accumulator clear
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer accepts result
result  out  N  registered result
flagZ  out  1  result == 0
flagN  out  1  result[N-1]
flagP  out  1  XOR-reduce of result
txn_count  out  CNT_W  number of accepted transactions, wraps

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all of the following are 0: out_valid, result, flagZ, flagN, flagP, acc, txn_count.
  - Exception: flagZ resets to 1, which is consistent with result=0.
- Reset mid-transaction discards the held result; no output is produced after release.
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 NOT A
  - 111 PASS B
- Operand A = acc_mode ? acc : a.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept occurs when in_valid & in_ready.
- Latency: 1 cycle. Inputs accepted on edge k give out_valid=1 with result and flags after edge k.
- Hold: while out_valid & !out_ready, the result register and flags hold stable.
- out_valid update on each edge:
  - accept → 1
  - else if out_ready → 0
  - else hold
- Full throughput: back-to-back accepts with out_ready=1 yield one result per cycle.
- Flags are computed from the combinational core result and registered together with result. They are never stale relative to result.
- Accumulator (acc, N bits, internal):
  - On accept: acc <= core result, regardless of acc_mode.
  - acc_clr=1 forces acc <= 0 on the edge and takes priority over the update.
  - acc_clr and accept in the same cycle: the accepted op uses the old acc value; the produced result is unaffected; acc becomes 0.
  - acc_clr with no accept does not change out_valid or result.
- txn_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0. It is not affected by acc_clr.
- in_valid=0 with out_ready=1 drains the output (out_valid -> 0). result and flags keep their last value.

Decomposition:
- Package logic_unit_pkg:
  - typedef enum logic [2:0] op_e: OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOTA, OP_PASSB.
  - Default-parameter constants.
- Sub-module logic_core #(N): purely combinational.
  - Inputs: a, b, op.
  - Outputs: res, z, n, p.
- Top level contains the handshake register, accumulator and counter.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> immediately out_valid=0, result=0, flagZ=1, txn_count=0.
- Op sweep, N=4, a=4'b1100, b=4'b1010, out_ready=1, one op per cycle from 000 to 111 -> results 1000, 1110, 0110, 0111, 0001, 1001, 0011, 1010 on consecutive cycles; flags match (e.g. XOR: Z=0, N=0, P=0); txn_count=8.
- Zero flag: AND with a=0101, b=1010 -> result 0000, flagZ=1, flagP=0, flagN=0.
- Back-pressure: out_ready=0 after the first result, in_valid held with a new op -> in_ready=0, result holds; raise out_ready -> next result appears the following cycle, with no loss or duplication.
- Accumulator:
  - acc_clr, then acc_mode=1, op=OR, b=0001, 0010, 0100 -> results 0001, 0011, 0111.
  - op=XOR, b=0111 -> result 0000, flagZ=1.
- Clear collision: acc=0111, acc_mode=1, op=AND, b=0101, with acc_clr in the same accept cycle -> result 0101; next op OR, b=0000 with acc_mode=1 -> result 0000. Also check txn_count wrap with CNT_W=2 after 4 accepts -> 0.

Source files
------------

// File: rtl/logic_unit_pipe_pkg.sv
// Shared op encoding and default widths for the registered logic unit.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NAND  = 3'b011,
    OP_NOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Combinational bitwise core: selected op on a/b plus zero, sign and odd-parity flags.
module logic_core
  import logic_unit_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  op_e          op,
  output logic [N-1:0] res,
  output logic         z,
  output logic         n,
  output logic         p
);

  always_comb begin
    res = '0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NAND:  res = ~(a & b);
      OP_NOR:   res = ~(a | b);
      OP_XNOR:  res = ~(a ^ b);
      OP_NOTA:  res = ~a;
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

  assign z = (res == '0);
  assign n = res[N-1];
  assign p = ^res;

endmodule

// File: rtl/logic_unit_pipe.sv
// One-stage registered logic unit with valid/ready handshake, feedback accumulator
// and wrapping accepted-transaction counter.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [2:0]       op,
  input  logic             acc_mode,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             flagZ,
  output logic             flagN,
  output logic             flagP,
  output logic [CNT_W-1:0] txn_count
);

  logic [N-1:0] acc;
  logic [N-1:0] op_a;
  logic [N-1:0] core_res;
  logic         core_z;
  logic         core_n;
  logic         core_p;
  logic         accept;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign op_a     = acc_mode ? acc : a;

  logic_core #(.N(N)) u_core (
    .a   (op_a),
    .b   (b),
    .op  (op_e'(op)),
    .res (core_res),
    .z   (core_z),
    .n   (core_n),
    .p   (core_p)
  );

  // Result and flags load together so the flags always describe the held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flagZ     <= 1'b1;
      flagN     <= 1'b0;
      flagP     <= 1'b0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        result    <= core_res;
        flagZ     <= core_z;
        flagN     <= core_n;
        flagP     <= core_p;
        txn_count <= txn_count + CNT_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Clear wins over update; an op accepted alongside a clear still saw the old acc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept) begin
      acc <= core_res;
    end
  end

endmodule
